// File: rtl/axil_sram_resp_pkg.sv
// Shared encodings for the AXI-lite data-RAM responder: response codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axil_sram_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

endpackage

// File: rtl/axil_sram_resp_bytewise_ram.sv
// Word-wide RAM with one synchronous read port and one byte-enabled write port.
// Latency: read data appears one edge after rd_en; writes land on the enabling edge.
// Backpressure: none; the caller sequences accesses.
module bytewise_ram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH_LOG2 = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rd_en,
    input  logic [DEPTH_LOG2-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wr_en,
    input  logic [DEPTH_LOG2-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [DATA_WIDTH-1:0]   wr_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Byte-lane write: only lanes with their strobe set are touched.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Registered read; a write on the same edge is not seen (old data returned).
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axil_sram_resp.sv
// AXI-lite single-beat responder fronting the on-chip data RAM, with OKAY/SLVERR decode.
// Latency: rvalid RD_LAT cycles after AR handshake; bvalid one cycle after joint AW/W handshake.
// Backpressure: one outstanding read and one outstanding write; channels stall until rready/bready.
module axil_sram_resp
    import axil_sram_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LAT     = 2,
    parameter string                 INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int TAG_LSB = DEPTH_LOG2 + 2;
    localparam int CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_WIDTH-TAG_LSB-1:0] BASE_TAG = BASE_ADDR[ADDR_WIDTH-1:TAG_LSB];

    // Byte-offset bits never select anything: the full word is always accessed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{araddr[1:0], awaddr[1:0]};

    logic ar_in_range, aw_in_range;
    assign ar_in_range = (araddr[ADDR_WIDTH-1:TAG_LSB] == BASE_TAG);
    assign aw_in_range = (awaddr[ADDR_WIDTH-1:TAG_LSB] == BASE_TAG);

    // ---------------- read side ----------------
    r_state_t              r_state, r_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] ar_idx;
    logic                  ar_ok;
    logic                  ar_hs, r_enter, rd_ok;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign ar_hs   = arready & arvalid;
    assign r_enter = (r_state != R_RESP) && (r_next == R_RESP);
    // With RD_LAT==1 the RAM is read on the handshake edge itself, so bypass the latch.
    assign rd_idx  = (r_state == R_IDLE) ? araddr[TAG_LSB-1:2] : ar_idx;
    assign rd_ok   = (r_state == R_IDLE) ? ar_in_range : ar_ok;

    // Read state, latched address and latency counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            ar_idx  <= '0;
            ar_ok   <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                ar_idx <= araddr[TAG_LSB-1:2];
                ar_ok  <= ar_in_range;
                r_cnt  <= CNT_LOAD;
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Read next-state: idle -> (wait) -> respond -> idle on rready.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (arvalid) r_next = (RD_LAT == 1) ? R_RESP : R_WAIT;
            R_WAIT: if (r_cnt == CNT_W'(1)) r_next = R_RESP;
            R_RESP: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read response code, captured together with the RAM read on entry to R_RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rresp <= RESP_OKAY;
        end else if (r_enter) begin
            rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read outputs; SLVERR and idle both present zero data.
    always_comb begin
        arready = (r_state == R_IDLE);
        rvalid  = (r_state == R_RESP);
        rdata   = (rvalid && rresp == RESP_OKAY) ? ram_rd_data : '0;
    end

    // ---------------- write side ----------------
    w_state_t w_state, w_next;
    logic     aw_hs;

    assign aw_hs = (w_state == W_IDLE) & awvalid & wvalid;

    // Write state and response code.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            bresp   <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                bresp <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Write next-state: accept AW+W together, hold B until bready.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (aw_hs) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write outputs; both channels are only ready when both are valid.
    always_comb begin
        awready = aw_hs;
        wready  = aw_hs;
        bvalid  = (w_state == W_RESP);
    end

    bytewise_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .rd_en   (r_enter),
        .rd_addr (rd_idx),
        .rd_data (ram_rd_data),
        .wr_en   (rst_n & aw_hs & aw_in_range),
        .wr_addr (awaddr[TAG_LSB-1:2]),
        .wr_strb (wstrb),
        .wr_data (wdata)
    );

endmodule

// File: tb/tb_axil_sram_resp.sv
// Directed bench for axil_sram_resp: reset values, strobed writes, decode errors,
// read backpressure, lone-channel stall and mid-transaction reset.
module tb_axil_sram_resp;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_sram_resp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH_LOG2 (12),
        .BASE_ADDR  (32'h8000_0000),
        .RD_LAT     (RD_LAT),
        .INIT_FILE  ("")
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("awready", {31'd0, awready}, 32'd1);
        check("wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clr", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        check("arready", {31'd0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_latency", n, RD_LAT);
        check("rdata", rdata, exp_d);
        check("rresp", {30'd0, rresp}, {30'd0, exp_r});
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_clr", {31'd0, rvalid}, 32'd0);
        check("arready_back", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", {30'd0, rresp}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_awready", {31'd0, awready}, 32'd0);

        // 1: full-word write then read back
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
        do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // 2: single-lane strobe merge, then an all-zero strobe that must change nothing
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0010, 2'b00);
        do_read(32'h8000_0020, 32'h1122_CC44, 2'b00);
        do_write(32'h8000_0022, 32'hFFFF_FFFF, 4'b0000, 2'b00);
        do_read(32'h8000_0023, 32'h1122_CC44, 2'b00);

        // 3: out-of-range read and write; word 0 must survive the aliased write
        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 2'b00);
        do_read(32'h0000_0000, 32'h0000_0000, 2'b10);
        do_write(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 2'b10);
        do_read(32'h8000_0000, 32'h0BAD_F00D, 2'b00);

        // 4: hold rready low for 5 cycles after rvalid
        @(negedge clk);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        repeat (RD_LAT - 1) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", {31'd0, rvalid}, 32'd1);
            check("hold_rdata", rdata, 32'hDEAD_BEEF);
            check("hold_arready", {31'd0, arready}, 32'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("hold_rvalid_clr", {31'd0, rvalid}, 32'd0);
        check("hold_arready_back", {31'd0, arready}, 32'd1);

        // 5: lone AW for 3 cycles, then W joins; extra valids during B must not commit
        @(negedge clk);
        awaddr = 32'h8000_0030; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lone_awready", {31'd0, awready}, 32'd0);
            check("lone_wready", {31'd0, wready}, 32'd0);
            @(negedge clk);
            check("lone_bvalid", {31'd0, bvalid}, 32'd0);
        end
        wvalid = 1'b1;
        #1;
        check("joint_awready", {31'd0, awready}, 32'd1);
        check("joint_wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        wdata = 32'h0000_0000;
        #1;
        check("joint_bvalid", {31'd0, bvalid}, 32'd1);
        check("busy_awready", {31'd0, awready}, 32'd0);
        @(negedge clk);
        check("busy_awready2", {31'd0, awready}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("joint_bvalid_clr", {31'd0, bvalid}, 32'd0);
        do_read(32'h8000_0030, 32'hCAFE_F00D, 2'b00);

        // 6: reset during R_WAIT
        @(negedge clk);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstr_rvalid", {31'd0, rvalid}, 32'd0);
        check("rstr_arready", {31'd0, arready}, 32'd1);
        @(negedge clk);
        check("rstr_rvalid_later", {31'd0, rvalid}, 32'd0);

        // 6: reset during W_RESP
        awaddr = 32'h8000_0040; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("rstw_bvalid_pre", {31'd0, bvalid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw_bvalid", {31'd0, bvalid}, 32'd0);
        check("rstw_bresp", {30'd0, bresp}, 32'd0);
        check("rstw_arready", {31'd0, arready}, 32'd1);
        do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        do_read(32'h8000_0040, 32'h5A5A_5A5A, 2'b00);
        do_read(32'h8000_0020, 32'h1122_CC44, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
